// File: rtl/board_io.sv
// board_io: memory-mapped LED/switch/key window with memory pass-through and CPU clock enable.
// Define BOARD_IO_STEP_EN to build the single-step FSM and the CTRL register.
module board_io #(
  parameter int DATA_WIDTH      = 32,
  parameter int ADDR_WIDTH      = 32,
  parameter int LED_COUNT       = 8,
  parameter int SW_COUNT        = 4,
  parameter int KEY_COUNT       = 2,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = 32'hFFFF_FF00
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  output logic [DATA_WIDTH-1:0] o_rdata,
  output logic                  o_mem_we,
  input  logic [DATA_WIDTH-1:0] i_mem_rdata,
  input  logic [SW_COUNT-1:0]   i_sw,
  input  logic [KEY_COUNT-1:0]  i_key,
  output logic [LED_COUNT-1:0]  o_led,
  output logic                  o_cpu_ce
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [5:0] OFF_LED   = 6'h00;
  localparam logic [5:0] OFF_SW    = 6'h01;
  localparam logic [5:0] OFF_KEY   = 6'h02;
  localparam logic [5:0] OFF_PRESS = 6'h03;
  localparam logic [5:0] OFF_CTRL  = 6'h04;

  logic                  inIo;
  logic                  ioWr;
  logic [5:0]            offset;
  logic [DATA_WIDTH-1:0] ioRdata;
  logic [1:0]            ctrlRdata;
  logic                  unusedBits;

  logic [LED_COUNT-1:0]  led_q, led_d;
  logic [SW_COUNT-1:0]   swMeta_q, swSync_q;
  logic [KEY_COUNT-1:0]  keyMeta_q, keySync_q;
  logic [KEY_COUNT-1:0]  keyStable_q, keyStable_d;
  logic [CNT_W-1:0]      keyCnt_q [KEY_COUNT];
  logic [CNT_W-1:0]      keyCnt_d [KEY_COUNT];
  logic [KEY_COUNT-1:0]  keyRise;
  logic [KEY_COUNT-1:0]  pressClr;
  logic [KEY_COUNT-1:0]  press_q, press_d;

  assign inIo       = (i_addr[ADDR_WIDTH-1:8] == BASE_ADDR[ADDR_WIDTH-1:8]);
  assign offset     = i_addr[7:2];
  assign ioWr       = i_we & inIo;
  assign o_mem_we   = i_we & ~inIo;
  assign o_rdata    = inIo ? ioRdata : i_mem_rdata;
  assign o_led      = led_q;
  assign unusedBits = ^{i_addr[1:0], i_wdata};

  assign led_d    = (ioWr && offset == OFF_LED) ? i_wdata[LED_COUNT-1:0] : led_q;
  assign pressClr = (ioWr && offset == OFF_PRESS) ? i_wdata[KEY_COUNT-1:0] : '0;

  // A key level is accepted only after it differs from the stable value for DEBOUNCE_CYCLES clocks.
  always_comb begin
    keyStable_d = keyStable_q;
    for (int k = 0; k < KEY_COUNT; k++) begin
      keyCnt_d[k] = '0;
      if (keySync_q[k] != keyStable_q[k]) begin
        if (keyCnt_q[k] == CNT_MAX) keyStable_d[k] = keySync_q[k];
        else                        keyCnt_d[k]    = keyCnt_q[k] + 1'b1;
      end
    end
  end

  // Set is OR-ed in after the clear so a press on the same edge as a W1C survives.
  assign keyRise = keyStable_d & ~keyStable_q;
  assign press_d = (press_q & ~pressClr) | keyRise;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      led_q       <= '0;
      swMeta_q    <= '0;
      swSync_q    <= '0;
      keyMeta_q   <= '0;
      keySync_q   <= '0;
      keyStable_q <= '0;
      keyCnt_q    <= '{default: '0};
      press_q     <= '0;
    end else begin
      led_q       <= led_d;
      swMeta_q    <= i_sw;
      swSync_q    <= swMeta_q;
      keyMeta_q   <= ~i_key;
      keySync_q   <= keyMeta_q;
      keyStable_q <= keyStable_d;
      keyCnt_q    <= keyCnt_d;
      press_q     <= press_d;
    end
  end

`ifdef BOARD_IO_STEP_EN
  typedef enum logic [1:0] {RUN = 2'd0, HALT = 2'd1, PULSE = 2'd2} state_t;

  state_t state_q, state_d;
  logic   mode_q, mode_d;
  logic   cpuCe;

  assign mode_d = (ioWr && offset == OFF_CTRL) ? i_wdata[0] : mode_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= RUN;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
    end
  end

  // Leaving step mode takes priority over a pending single-step press.
  always_comb begin
    state_d = state_q;
    cpuCe   = 1'b1;
    case (state_q)
      RUN:   if (mode_q) state_d = HALT;
      HALT: begin
        cpuCe = 1'b0;
        if (!mode_q)         state_d = RUN;
        else if (keyRise[0]) state_d = PULSE;
      end
      PULSE:   state_d = mode_q ? HALT : RUN;
      default: state_d = RUN;
    endcase
  end

  assign o_cpu_ce  = cpuCe;
  assign ctrlRdata = {state_q == HALT, mode_q};
`else
  assign o_cpu_ce  = 1'b1;
  assign ctrlRdata = 2'b00;
`endif

  always_comb begin
    ioRdata = '0;
    case (offset)
      OFF_LED:   ioRdata = DATA_WIDTH'(led_q);
      OFF_SW:    ioRdata = DATA_WIDTH'(swSync_q);
      OFF_KEY:   ioRdata = DATA_WIDTH'(keyStable_q);
      OFF_PRESS: ioRdata = DATA_WIDTH'(press_q);
      OFF_CTRL:  ioRdata = DATA_WIDTH'(ctrlRdata);
      default:   ioRdata = '0;
    endcase
  end

endmodule

// File: tb/tb_board_io.sv
// tb_board_io: directed scoreboard bench for board_io with an 8-cycle debounce.
// Step-mode checks follow BOARD_IO_STEP_EN; the default build checks the tied-high clock enable.
module tb_board_io;

  localparam logic [31:0] BASE      = 32'hFFFF_FF00;
  localparam logic [31:0] IDLE_ADDR = 32'h0000_1000;
  localparam logic [31:0] MEM_DATA  = 32'hDEAD_BEEF;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_we;
  logic [31:0] i_addr;
  logic [31:0] i_wdata;
  logic [31:0] o_rdata;
  logic        o_mem_we;
  logic [31:0] i_mem_rdata;
  logic [3:0]  i_sw;
  logic [1:0]  i_key;
  logic [7:0]  o_led;
  logic        o_cpu_ce;

  typedef struct {
    string       tag;
    logic [31:0] value;
  } expect_t;

  expect_t sbQ[$];
  int      errors = 0;
  int      checks = 0;

  board_io #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .LED_COUNT(8), .SW_COUNT(4),
    .KEY_COUNT(2), .DEBOUNCE_CYCLES(8), .BASE_ADDR(32'hFFFF_FF00)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_we(i_we), .i_addr(i_addr),
    .i_wdata(i_wdata), .o_rdata(o_rdata), .o_mem_we(o_mem_we),
    .i_mem_rdata(i_mem_rdata), .i_sw(i_sw), .i_key(i_key),
    .o_led(o_led), .o_cpu_ce(o_cpu_ce)
  );

  always #10 i_clk = ~i_clk;

  task automatic pushExpect(input string tag, input logic [31:0] value);
    expect_t e;
    e.tag   = tag;
    e.value = value;
    sbQ.push_back(e);
  endtask

  task automatic checkOutput(input logic [31:0] observed);
    expect_t e;
    checks++;
    if (sbQ.size() == 0) begin
      errors++;
      $display("[TB] FAIL scoreboard-empty observed=%h expected=<none>", observed);
    end else begin
      e = sbQ.pop_front();
      assert (observed === e.value) else begin
        errors++;
        $error("[TB] FAIL %s observed=%h expected=%h", e.tag, observed, e.value);
      end
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data);
    i_we    = 1'b1;
    i_addr  = addr;
    i_wdata = data;
    @(posedge i_clk);
    #1;
    i_we    = 1'b0;
    i_addr  = IDLE_ADDR;
    i_wdata = '0;
  endtask

  task automatic readCheck(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    i_we   = 1'b0;
    i_addr = addr;
    #1;
    pushExpect(tag, exp);
    checkOutput(o_rdata);
    i_addr = IDLE_ADDR;
  endtask

  task automatic valueCheck(input string tag, input logic [31:0] observed, input logic [31:0] exp);
    pushExpect(tag, exp);
    checkOutput(observed);
  endtask

  initial begin
    int highs;
    int run;
    int maxRun;
    logic seen;

    i_rst       = 1'b1;
    i_we        = 1'b0;
    i_addr      = IDLE_ADDR;
    i_wdata     = '0;
    i_mem_rdata = MEM_DATA;
    i_sw        = 4'h0;
    i_key       = 2'b11;
    tick(3);
    i_rst = 1'b0;

    // Reset state of every mapped register and the outputs.
    readCheck("rst_led",   BASE + 32'h00, 32'h0);
    readCheck("rst_sw",    BASE + 32'h04, 32'h0);
    readCheck("rst_key",   BASE + 32'h08, 32'h0);
    readCheck("rst_press", BASE + 32'h0C, 32'h0);
    readCheck("rst_ctrl",  BASE + 32'h10, 32'h0);
    valueCheck("rst_o_led", 32'(o_led), 32'h0);
    valueCheck("rst_ce",    32'(o_cpu_ce), 32'h1);

    // LED write inside the window, memory write outside it.
    i_we = 1'b1; i_addr = BASE; i_wdata = 32'hA5; #1;
    valueCheck("io_mem_we", 32'(o_mem_we), 32'h0);
    @(posedge i_clk); #1;
    i_we = 1'b0; i_addr = IDLE_ADDR;
    valueCheck("led_out", 32'(o_led), 32'hA5);
    i_we = 1'b1; i_addr = 32'h0000_0040; i_wdata = 32'h1234; #1;
    valueCheck("mem_we", 32'(o_mem_we), 32'h1);
    valueCheck("mem_rdata", o_rdata, MEM_DATA);
    @(posedge i_clk); #1;
    i_we = 1'b0; i_addr = IDLE_ADDR;
    readCheck("led_read",    BASE + 32'h03, 32'hA5);
    readCheck("below_base",  BASE - 32'h4,  MEM_DATA);
    readCheck("unmapped",    BASE + 32'h20, 32'h0);
    applyStimulus(BASE + 32'h24, 32'hFFFF_FFFF);
    readCheck("led_kept",    BASE + 32'h00, 32'hA5);

    // Two-flop switch synchroniser.
    i_sw = 4'hA;
    tick(1);
    readCheck("sw_1cyc", BASE + 32'h04, 32'h0);
    tick(1);
    readCheck("sw_2cyc", BASE + 32'h04, 32'hA);

    // Five-cycle glitch on key 1 must be rejected.
    i_key = 2'b01;
    tick(5);
    i_key = 2'b11;
    tick(12);
    readCheck("glitch_key",   BASE + 32'h08, 32'h0);
    readCheck("glitch_press", BASE + 32'h0C, 32'h0);

    // Held press on key 1: accepted on the tenth edge.
    i_key = 2'b01;
    tick(9);
    readCheck("key1_early", BASE + 32'h08, 32'h0);
    tick(1);
    readCheck("key1_on",    BASE + 32'h08, 32'h2);
    readCheck("press1_on",  BASE + 32'h0C, 32'h2);
    applyStimulus(BASE + 32'h0C, 32'h1);
    readCheck("w1c_other",  BASE + 32'h0C, 32'h2);
    applyStimulus(BASE + 32'h0C, 32'h2);
    readCheck("w1c_clear",  BASE + 32'h0C, 32'h0);
    i_key = 2'b11;
    tick(12);
    readCheck("key1_off",     BASE + 32'h08, 32'h0);
    readCheck("release_none", BASE + 32'h0C, 32'h0);

    // Key 0 press lands on the same edge as a W1C of bit 0: set wins.
    i_key = 2'b10;
    tick(9);
    applyStimulus(BASE + 32'h0C, 32'h1);
    readCheck("set_wins", BASE + 32'h0C, 32'h1);
    applyStimulus(BASE + 32'h0C, 32'h1);
    readCheck("press0_clear", BASE + 32'h0C, 32'h0);
    i_key = 2'b11;
    tick(12);

    // Reset mid-debounce restarts synchroniser and counter from zero.
    i_key = 2'b10;
    tick(6);
    i_rst = 1'b1;
    tick(1);
    i_rst = 1'b0;
    readCheck("rst_led_cleared", BASE + 32'h00, 32'h0);
    tick(9);
    readCheck("rst_deb_early", BASE + 32'h08, 32'h0);
    tick(1);
    readCheck("rst_deb_done",  BASE + 32'h08, 32'h1);
    i_key = 2'b11;
    tick(12);
    applyStimulus(BASE + 32'h0C, 32'h3);
    readCheck("press_cleanup", BASE + 32'h0C, 32'h0);

`ifdef BOARD_IO_STEP_EN
    // Entering step mode: still running one edge after the write, halted after the second.
    applyStimulus(BASE + 32'h10, 32'h1);
    valueCheck("halt_edge1", 32'(o_cpu_ce), 32'h1);
    tick(1);
    valueCheck("halt_edge2", 32'(o_cpu_ce), 32'h0);
    readCheck("ctrl_halted", BASE + 32'h10, 32'h3);

    highs = 0; maxRun = 0; run = 0;
    for (int p = 0; p < 2; p++) begin
      i_key = 2'b10;
      for (int c = 0; c < 40; c++) begin
        tick(1);
        if (o_cpu_ce) begin
          highs++;
          run++;
          if (run > maxRun) maxRun = run;
        end else begin
          run = 0;
        end
        if (c == 19) i_key = 2'b11;
      end
    end
    valueCheck("step_pulses",   32'(highs),  32'd2);
    valueCheck("step_pulse_len", 32'(maxRun), 32'd1);
    readCheck("step_press0", BASE + 32'h0C, 32'h1);
    applyStimulus(BASE + 32'h0C, 32'h1);

    // Reset while in PULSE returns to RUN with CTRL cleared.
    i_key = 2'b10;
    seen  = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tick(1);
      if (o_cpu_ce) begin
        seen = 1'b1;
        break;
      end
    end
    valueCheck("pulse_seen", 32'(seen), 32'h1);
    i_rst = 1'b1;
    tick(1);
    i_rst = 1'b0;
    valueCheck("pulse_rst_ce", 32'(o_cpu_ce), 32'h1);
    readCheck("pulse_rst_ctrl",  BASE + 32'h10, 32'h0);
    readCheck("pulse_rst_press", BASE + 32'h0C, 32'h0);
    tick(3);
    valueCheck("pulse_rst_run", 32'(o_cpu_ce), 32'h1);
    i_key = 2'b11;
    tick(12);

    // Leaving step mode resumes a continuous clock enable.
    applyStimulus(BASE + 32'h10, 32'h1);
    tick(2);
    valueCheck("rehalt_ce", 32'(o_cpu_ce), 32'h0);
    applyStimulus(BASE + 32'h10, 32'h0);
    highs = 0;
    for (int c = 0; c < 10; c++) begin
      tick(1);
      if (o_cpu_ce) highs++;
    end
    valueCheck("run_continuous", 32'(highs), 32'd10);
    readCheck("ctrl_run", BASE + 32'h10, 32'h0);
`else
    // Without the step feature CTRL is inert and the clock enable never drops.
    applyStimulus(BASE + 32'h10, 32'h1);
    tick(2);
    readCheck("ctrl_absent", BASE + 32'h10, 32'h0);
    highs = 0;
    i_key = 2'b10;
    for (int c = 0; c < 40; c++) begin
      tick(1);
      if (o_cpu_ce) highs++;
      if (c == 19) i_key = 2'b11;
    end
    valueCheck("ce_tied_high", 32'(highs), 32'd40);
    readCheck("nostep_press0", BASE + 32'h0C, 32'h1);
`endif

    valueCheck("scoreboard_drained", 32'(sbQ.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
